// File: rtl/bus_init_pkg.sv
// Shared types for the bus initiator: FSM state encoding and timeout counter width.
package bus_init_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_init_timer.sv
// REQ wait counter; expired is high during the TIMEOUT-th enabled cycle after clear.
module bus_init_timer
    import bus_init_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Saturate once expired so a stalled FSM can never wrap the count.
    always_comb begin
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = '0;
        end else if (enable && !expired) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (clear || enable) begin
            cnt     <= cnt_nxt;
            expired <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: command in, one responder request, held response out.
// Optional responder timeout with error response when BUS_INIT_TIMEOUT_EN is defined.
module bus_initiator
    import bus_init_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              valid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready
`ifdef BUS_INIT_TIMEOUT_EN
    ,
    output logic              rsp_err
`endif
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_initiator: TIMEOUT must be in 1..255");
    end

    state_e state;
    state_e state_nxt;
    logic   accept;
    logic   capture;
`ifdef BUS_INIT_TIMEOUT_EN
    logic   expired;
    logic   timeout_hit;
`endif

    assign accept = cmd_valid && cmd_ready;

`ifdef BUS_INIT_TIMEOUT_EN
    bus_init_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (state == REQ),
        .expired (expired)
    );
`endif

    // Next state; ready wins over a same-cycle timeout expiry.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
`ifdef BUS_INIT_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ready) begin
                    state_nxt = RSP;
                    capture   = 1'b1;
`ifdef BUS_INIT_TIMEOUT_EN
                end else if (expired) begin
                    state_nxt   = RSP;
                    timeout_hit = 1'b1;
`endif
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            valid     <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            valid     <= (state_nxt == REQ);
            rsp_valid <= (state_nxt == RSP);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr  <= '0;
            wdata <= '0;
        end else if (accept) begin
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data <= '0;
        end else if (capture) begin
            rsp_data <= rdata;
`ifdef BUS_INIT_TIMEOUT_EN
        end else if (timeout_hit) begin
            rsp_data <= '0;
`endif
        end
    end

`ifdef BUS_INIT_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err <= 1'b0;
        end else if (capture || timeout_hit) begin
            rsp_err <= timeout_hit;
        end
    end
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboard bench for bus_initiator; timeout scenarios run when BUS_INIT_TIMEOUT_EN is defined.
module tb_bus_initiator;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic       valid;
    logic [3:0] rdata;
    logic       ready;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_ready;
`ifdef BUS_INIT_TIMEOUT_EN
    logic       rsp_err;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    bus_initiator #(
        .ADDR_W  (4),
        .DATA_W  (4),
        .TIMEOUT (15)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .addr      (addr),
        .wdata     (wdata),
        .valid     (valid),
        .rdata     (rdata),
        .ready     (ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
`ifdef BUS_INIT_TIMEOUT_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (cmd_ready !== 1'b1 || valid !== 1'b0 || rsp_valid !== 1'b0 ||
            addr !== 4'h0 || wdata !== 4'h0 || rsp_data !== 4'h0) begin
            failures++;
            $display("FAIL reset_state cmd_ready=%b valid=%b rsp_valid=%b addr=%h wdata=%h rsp_data=%h, want 1 0 0 0 0 0",
                     cmd_ready, valid, rsp_valid, addr, wdata, rsp_data);
        end
`ifdef BUS_INIT_TIMEOUT_EN
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err rsp_err=%b want 0", rsp_err);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        // Stray ready in IDLE must not start anything.
        ready = 1'b1;
        rdata = 4'h5;
        @(negedge clock);
        checks++;
        if (valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready valid=%b rsp_valid=%b cmd_ready=%b want 0 0 1", valid, rsp_valid, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_addr  = 4'ha;
        cmd_wdata = 4'h4;
        exp_q.push_back(exp_t'{data: 4'h5, err: 1'b0});
        @(negedge clock);
        checks++;
        if (valid !== 1'b1 || addr !== 4'ha || wdata !== 4'h4 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_req valid=%b addr=%h wdata=%h cmd_ready=%b want 1 a 4 0", valid, addr, wdata, cmd_ready);
        end
        cmd_valid = 1'b0;
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== e.data) begin
            failures++;
            $display("FAIL basic_rsp valid=%b rsp_valid=%b rsp_data=%h want 0 1 %h", valid, rsp_valid, rsp_data, e.data);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || addr !== 4'ha || wdata !== 4'h4) begin
            failures++;
            $display("FAIL basic_done cmd_ready=%b rsp_valid=%b addr=%h wdata=%h want 1 0 a 4", cmd_ready, rsp_valid, addr, wdata);
        end
        rsp_ready = 1'b0;
        ready     = 1'b0;
    endtask

    task automatic test_delayed_ready();
        exp_t e;
        int   bad = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_addr  = 4'h3;
        cmd_wdata = 4'hc;
        exp_q.push_back(exp_t'{data: 4'hd, err: 1'b0});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            cmd_addr  = 4'(i);
            cmd_wdata = 4'(i + 8);
            if (valid !== 1'b1 || addr !== 4'h3 || wdata !== 4'hc) bad++;
            rdata = 4'(i);
            if (i == 4) begin
                ready = 1'b1;
                rdata = 4'hd;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL delayed_hold bad_cycles=%0d want 0", bad);
        end
        @(negedge clock);
        ready = 1'b0;
        rdata = 4'h1;
        e = exp_q.pop_front();
        checks++;
        if (valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== e.data) begin
            failures++;
            $display("FAIL delayed_rsp valid=%b rsp_valid=%b rsp_data=%h want 0 1 %h", valid, rsp_valid, rsp_data, e.data);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   bad = 0;
        cmd_valid = 1'b1;
        cmd_addr  = 4'h7;
        cmd_wdata = 4'h1;
        ready     = 1'b1;
        rdata     = 4'h6;
        exp_q.push_back(exp_t'{data: 4'h6, err: 1'b0});
        @(negedge clock);
        checks++;
        if (valid !== 1'b1 || addr !== 4'h7) begin
            failures++;
            $display("FAIL b2b_req valid=%b addr=%h want 1 7", valid, addr);
        end
        cmd_addr  = 4'h8;
        cmd_wdata = 4'h2;
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || valid !== 1'b0 || rsp_data !== e.data) bad++;
            rdata = 4'(i + 9);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_stall bad_cycles=%0d want 0", bad);
        end
        rdata = 4'hb;
        exp_q.push_back(exp_t'{data: 4'hb, err: 1'b0});
        rsp_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || valid !== 1'b0 || addr !== 4'h7) begin
            failures++;
            $display("FAIL b2b_release cmd_ready=%b rsp_valid=%b valid=%b addr=%h want 1 0 0 7", cmd_ready, rsp_valid, valid, addr);
        end
        rsp_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (valid !== 1'b1 || addr !== 4'h8 || wdata !== 4'h2) begin
            failures++;
            $display("FAIL b2b_second valid=%b addr=%h wdata=%h want 1 8 2", valid, addr, wdata);
        end
        cmd_valid = 1'b0;
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data) begin
            failures++;
            $display("FAIL b2b_second_rsp rsp_valid=%b rsp_data=%h want 1 %h", rsp_valid, rsp_data, e.data);
        end
        rsp_ready = 1'b1;
        ready     = 1'b0;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   seen = 0;
        cmd_valid = 1'b1;
        cmd_addr  = 4'hb;
        cmd_wdata = 4'he;
        ready     = 1'b0;
        exp_q.push_back(exp_t'{data: 4'h0, err: 1'b0});
        @(negedge clock);
        cmd_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        // An aborted transaction never responds.
        void'(exp_q.pop_back());
        checks++;
        if (valid !== 1'b0 || rsp_valid !== 1'b0 || addr !== 4'h0 || wdata !== 4'h0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_async valid=%b rsp_valid=%b addr=%h wdata=%h cmd_ready=%b want 0 0 0 0 1",
                     valid, rsp_valid, addr, wdata, cmd_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_rsp spurious_cycles=%0d want 0", seen);
        end
        cmd_valid = 1'b1;
        cmd_addr  = 4'h2;
        cmd_wdata = 4'h5;
        rdata     = 4'ha;
        exp_q.push_back(exp_t'{data: 4'ha, err: 1'b0});
        @(negedge clock);
        cmd_valid = 1'b0;
        checks++;
        if (valid !== 1'b1 || addr !== 4'h2 || wdata !== 4'h5) begin
            failures++;
            $display("FAIL abort_next_req valid=%b addr=%h wdata=%h want 1 2 5", valid, addr, wdata);
        end
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data) begin
            failures++;
            $display("FAIL abort_next_rsp rsp_valid=%b rsp_data=%h want 1 %h", rsp_valid, rsp_data, e.data);
        end
        rsp_ready = 1'b1;
        ready     = 1'b0;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

`ifdef BUS_INIT_TIMEOUT_EN
    task automatic test_timeout(input logic race);
        exp_t e;
        int   bad = 0;
        cmd_valid = 1'b1;
        cmd_addr  = 4'h9;
        cmd_wdata = 4'h3;
        ready     = 1'b0;
        rdata     = 4'hf;
        exp_q.push_back(race ? exp_t'{data: 4'h7, err: 1'b0} : exp_t'{data: 4'h0, err: 1'b1});
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            if (valid !== 1'b1 || rsp_valid !== 1'b0) bad++;
            if (race && i == 15) begin
                ready = 1'b1;
                rdata = 4'h7;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timeout_wait race=%b bad_cycles=%0d want 0", race, bad);
        end
        @(negedge clock);
        ready = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_data !== e.data) begin
            failures++;
            $display("FAIL timeout_rsp race=%b valid=%b rsp_valid=%b rsp_err=%b rsp_data=%h want 0 1 %b %h",
                     race, valid, rsp_valid, rsp_err, rsp_data, e.err, e.data);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 4'h0;
        rdata     = 4'h0;
        ready     = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_delayed_ready();
        test_back_to_back();
        test_reset_abort();
`ifdef BUS_INIT_TIMEOUT_EN
        test_timeout(1'b0);
        test_timeout(1'b1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter ADDR_W, default 4, address width of the responder bus.
REQ-002 Parameter DATA_W, default 4, wdata/rdata width.
REQ-003 Parameter TIMEOUT, default 15, max cycles to wait for ready; legal range 1..255.
REQ-004 Ports, clock and reset first:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  command write data.
- addr  out  ADDR_W  address to responder.
- wdata  out  DATA_W  write data to responder.
- valid  out  1  request to responder.
- rdata  in  DATA_W  responder read data.
- ready  in  1  responder completion.
- rsp_valid  out  1  response held for consumer.
- rsp_data  out  DATA_W  captured rdata.
- rsp_ready  in  1  consumer accepts the response when rsp_valid && rsp_ready.
- rsp_err  out  1  response is a timeout; present only with BUS_INIT_TIMEOUT_EN.

Function
REQ-005 The FSM SHALL have states IDLE, REQ and RSP.
REQ-006 IDLE SHALL assert cmd_ready=1 and keep valid=0 and rsp_valid=0.
REQ-007 On cmd_valid&&cmd_ready, cmd_addr and cmd_wdata SHALL be registered to addr and wdata, and the FSM SHALL go to REQ on the next edge.
REQ-008 REQ SHALL assert valid=1 with addr and wdata held stable, and cmd_ready=0.
REQ-009 In REQ with ready=1, rdata SHALL be captured into rsp_data, valid SHALL drop the next cycle, and the FSM SHALL go to RSP.
REQ-010 Latency SHALL be exactly one cycle from the accepting edge to valid=1, and one cycle from ready=1 to rsp_valid=1.
REQ-011 RSP SHALL assert rsp_valid=1 and hold rsp_data and rsp_err stable until rsp_ready=1, then return to IDLE.
REQ-012 A new command SHALL NOT be accepted while in REQ or RSP, so at most one transaction is outstanding.
REQ-013 A ready asserted in IDLE or RSP SHALL be ignored.
REQ-014 A responder that holds ready=1 permanently, combinationally or not, SHALL complete each request in one REQ cycle.
REQ-015 addr and wdata SHALL retain their last values in IDLE and RSP.

Reset
REQ-016 While reset_n=0, the FSM SHALL be IDLE with valid=0, rsp_valid=0, rsp_err=0, and addr, wdata and rsp_data all 0.
REQ-017 Reset SHALL take effect immediately, asynchronously; deassertion SHALL be sampled on clock.
REQ-018 Reset asserted in REQ or RSP SHALL abort the transaction, drop valid and rsp_valid, and produce no response.
REQ-019 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-020 Macro BUS_INIT_TIMEOUT_EN SHALL control the timeout feature.
REQ-021 With BUS_INIT_TIMEOUT_EN defined:
- a wait counter SHALL clear on entry to REQ and count REQ cycles.
- if ready has not arrived after TIMEOUT cycles in REQ, the FSM SHALL go to RSP with rsp_err=1 and rsp_data=0, dropping valid.
- if ready=1 arrives on the same cycle as expiry, ready SHALL win and rsp_err=0.
REQ-022 Without the macro, the rsp_err port and the counter SHALL be absent, and REQ SHALL wait indefinitely.

Structure
REQ-023 Package bus_init_pkg SHALL hold the state enum (IDLE/REQ/RSP) and the counter width localparam, 8 bits.
REQ-024 The timeout counter SHALL be sub-module bus_init_timer (inputs clear/enable, output expired), instantiated only under BUS_INIT_TIMEOUT_EN.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Command addr=4'ha, wdata=4'h4; responder ready=1 always with rdata=4'h5 -> valid high one cycle with addr=a, wdata=4; rsp_valid next cycle with rsp_data=5; cmd_ready back to 1 after rsp_ready.
- ready delayed 3 cycles -> valid held 4 cycles, addr/wdata stable, and rsp_data equal to the rdata of the ready cycle.
- cmd_valid held high throughout; rsp_ready stalled 5 cycles -> cmd_ready=0, no second valid until the response is accepted, and rsp_data stable.
- reset_n pulsed low mid-REQ -> valid=0 and rsp_valid=0 immediately; addr=0; next command proceeds normally.
- BUS_INIT_TIMEOUT_EN with TIMEOUT=15 and ready never asserted -> after 15 REQ cycles, rsp_valid=1, rsp_err=1, rsp_data=0.
- BUS_INIT_TIMEOUT_EN with ready=1 on the 15th REQ cycle -> rsp_err=0 and rsp_data equal to rdata.
